// File: rtl/dsc_mul_seq.sv
// Sequencer for the serial deterministic stochastic multiplier.
// Runs one operand set through the cascaded SNG datapath and returns the count.
module dsc_mul_seq #(
    parameter int SNG_WIDTH  = 10,
    parameter int NUM_INPUTS = 4,
    parameter int CLR_CYCLES = 2,
    parameter int TO_MARGIN  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  op_data,
    input  logic                             abort,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0]  res_data,
    output logic                             res_err,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0]  mul_ops,
    output logic                             mul_rst,
    output logic                             mul_en,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  mul_z,
    input  logic                             mul_ov,
    output logic                             busy
);

    localparam int W  = NUM_INPUTS * SNG_WIDTH;
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    // Last RUN cycle before the watchdog reaches 2^W + TO_MARGIN.
    localparam logic [W:0] WD_LAST =
        {1'b1, {W{1'b0}}} + (W+1)'(TO_MARGIN) - (W+1)'(1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] clr_cnt;
    logic [W:0]    wd_cnt;
    logic          ov_s1;
    logic          ov_s2;
    logic          ov_s3;
    logic          ov_pulse;
    logic          op_zero;
    logic          wd_hit;

    always_comb begin
        op_zero = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (op_data[i*SNG_WIDTH +: SNG_WIDTH] == '0) begin
                op_zero = 1'b1;
            end
        end
    end

    // mul_ov comes from a ripple-clocked stage, so resynchronise it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_s1 <= 1'b0;
            ov_s2 <= 1'b0;
            ov_s3 <= 1'b0;
        end else if (state == S_CLEAR) begin
            ov_s1 <= 1'b0;
            ov_s2 <= 1'b0;
            ov_s3 <= 1'b0;
        end else begin
            ov_s1 <= mul_ov;
            ov_s2 <= ov_s1;
            ov_s3 <= ov_s2;
        end
    end

    assign ov_pulse = ov_s2 & ~ov_s3;
    assign wd_hit   = (wd_cnt == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (op_valid) begin
                    state_d = op_zero ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (clr_cnt == CLR_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort || (!ov_pulse && wd_hit)) begin
                    state_d = S_DONE;
                end else if (ov_pulse) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_ops  <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            clr_cnt  <= '0;
            wd_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    clr_cnt <= '0;
                    wd_cnt  <= '0;
                    if (op_valid) begin
                        mul_ops  <= op_data;
                        res_data <= '0;
                        res_err  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + CW'(1);
                    wd_cnt  <= '0;
                    if (abort) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end
                end
                S_RUN: begin
                    wd_cnt <= wd_cnt + (W+1)'(1);
                    if (abort) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end else if (!ov_pulse && wd_hit) begin
                        res_data <= mul_z;
                        res_err  <= 1'b1;
                    end
                end
                S_CAPT: begin
                    res_data <= mul_z;
                    res_err  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign op_ready  = (state == S_IDLE);
    assign res_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign mul_rst   = !((state == S_RUN) || (state == S_CAPT));
    // Enable drops in the very cycle the overflow edge is seen.
    assign mul_en    = (state == S_RUN) && !ov_pulse;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Bench for dsc_mul_seq: cascaded-counter datapath model, vector table,
// corner sequences and random jobs checked against a*b.
module tb_dsc_mul_seq;

    localparam int SW  = 3;
    localparam int NI  = 2;
    localparam int W   = SW * NI;
    localparam int CLR = 2;
    localparam int TOM = 8;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         op_valid  = 1'b0;
    logic         op_ready;
    logic [W-1:0] op_data   = '0;
    logic         abort     = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_err;
    logic [W-1:0] mul_ops;
    logic         mul_rst;
    logic         mul_en;
    logic [W-1:0] mul_z     = '0;
    logic         mul_ov    = 1'b0;
    logic         busy;

    logic [W-1:0] cnt         = '0;
    bit           suppress_ov = 1'b0;
    int           errors      = 0;
    int           checks      = 0;

    dsc_mul_seq #(
        .SNG_WIDTH (SW),
        .NUM_INPUTS(NI),
        .CLR_CYCLES(CLR),
        .TO_MARGIN (TOM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_data  (op_data),
        .abort    (abort),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_err  (res_err),
        .mul_ops  (mul_ops),
        .mul_rst  (mul_rst),
        .mul_en   (mul_en),
        .mul_z    (mul_z),
        .mul_ov   (mul_ov),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Datapath: one 6-bit count split into two 3-bit SNG counters; the
    // output counter adds a hit when both SNG bits are high. Halts at ov.
    always @(posedge clk) begin
        if (mul_rst) begin
            cnt    <= '0;
            mul_z  <= '0;
            mul_ov <= 1'b0;
        end else if (mul_en && !mul_ov) begin
            if ((cnt[2:0] < mul_ops[2:0]) && (cnt[5:3] < mul_ops[5:3])) begin
                mul_z <= mul_z + 1'b1;
            end
            cnt <= cnt + 1'b1;
            if (cnt == '1 && !suppress_ov) begin
                mul_ov <= 1'b1;
            end
        end
    end

    function automatic int ref_hits(input int a, input int b, input int n);
        int h;
        h = 0;
        for (int k = 0; k < n; k++) begin
            int c;
            c = k % 64;
            if ((c % 8) < a && (c / 8) < b) begin
                h++;
            end
        end
        return h;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_job(input int a, input int b, input int hold,
                          output int d, output int e, output int en_n);
        int n;
        bit rst_low;
        bit saw_ready;
        op_data  = W'((b << SW) | a);
        op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(op_ready), 64'd1);
        @(negedge clk);
        op_valid  = 1'b0;
        en_n      = 0;
        n         = 0;
        rst_low   = 1'b0;
        saw_ready = 1'b0;
        while (!res_valid && n < 300) begin
            if (mul_en) en_n++;
            if (!mul_rst) rst_low = 1'b1;
            if (op_ready) saw_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("res_valid_wait", 64'(res_valid), 64'd1);
        chk("op_ready_busy", 64'(saw_ready), 64'd0);
        if (a == 0 || b == 0) begin
            chk("zero_en", 64'(en_n), 64'd0);
            chk("zero_rst", 64'(rst_low), 64'd0);
            chk("zero_latency", 64'(n <= 1), 64'd1);
        end
        d = int'(res_data);
        e = int'(res_err);
        for (int i = 0; i < hold; i++) begin
            op_valid = 1'b1;
            op_data  = 6'o11;
            @(negedge clk);
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_data", 64'(res_data), 64'(d));
            chk("hold_opready", 64'(op_ready), 64'd0);
        end
        if (hold > 0) begin
            chk("ops_held", 64'(mul_ops), 64'((b << SW) | a));
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_valid", 64'(res_valid), 64'd0);
        chk("post_ready", 64'(op_ready), 64'd1);
    endtask

    typedef struct {
        int a;
        int b;
        int hold;
        int exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int d;
        int e;
        int en_n;
        int n;
        int a;
        int b;

        tbl[0] = '{a: 4, b: 6, hold: 0,  exp: 24};
        tbl[1] = '{a: 0, b: 7, hold: 0,  exp: 0};
        tbl[2] = '{a: 7, b: 7, hold: 10, exp: 49};
        tbl[3] = '{a: 1, b: 1, hold: 0,  exp: 1};
        tbl[4] = '{a: 5, b: 0, hold: 2,  exp: 0};
        tbl[5] = '{a: 7, b: 1, hold: 0,  exp: 7};
        tbl[6] = '{a: 2, b: 3, hold: 1,  exp: 6};
        tbl[7] = '{a: 6, b: 5, hold: 0,  exp: 30};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_op_ready", 64'(op_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_err", 64'(res_err), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_mul_ops", 64'(mul_ops), 64'd0);
        chk("rst_mul_rst", 64'(mul_rst), 64'd1);
        chk("rst_mul_en", 64'(mul_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            do_job(tbl[i].a, tbl[i].b, tbl[i].hold, d, e, en_n);
            chk("tbl_data", 64'(d), 64'(tbl[i].exp));
            chk("tbl_err", 64'(e), 64'd0);
            if (tbl[i].exp != 0) begin
                chk("tbl_run_len", 64'(en_n >= 64 && en_n <= 68), 64'd1);
            end
        end

        // Abort at RUN cycle 20.
        op_data  = W'((5 << SW) | 5);
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (!mul_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_run_start", 64'(mul_en), 64'd1);
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_en_drop", 64'(mul_en), 64'd0);
        chk("abort_valid", 64'(res_valid), 64'd1);
        chk("abort_err", 64'(res_err), 64'd1);
        chk("abort_data", 64'(res_data), 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ignored_done", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        do_job(2, 3, 0, d, e, en_n);
        chk("after_abort_data", 64'(d), 64'd6);
        chk("after_abort_err", 64'(e), 64'd0);

        // Watchdog: overflow never raised.
        suppress_ov = 1'b1;
        do_job(3, 2, 0, d, e, en_n);
        suppress_ov = 1'b0;
        chk("wd_err", 64'(e), 64'd1);
        chk("wd_run_len", 64'(en_n), 64'd72);
        chk("wd_data", 64'(d), 64'(ref_hits(3, 2, 71)));

        // Reset mid-RUN.
        op_data  = W'((7 << SW) | 7);
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (!mul_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_en", 64'(mul_en), 64'd0);
        chk("mid_rst_mrst", 64'(mul_rst), 64'd1);
        chk("mid_rst_ops", 64'(mul_ops), 64'd0);
        chk("mid_rst_ready", 64'(op_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale_valid", 64'(res_valid), 64'd0);
        end
        do_job(3, 1, 0, d, e, en_n);
        chk("after_rst_data", 64'(d), 64'd3);
        chk("after_rst_err", 64'(e), 64'd0);

        for (int i = 0; i < 16; i++) begin
            a = int'($urandom_range(0, 7));
            b = int'($urandom_range(0, 7));
            do_job(a, b, int'($urandom_range(0, 3)), d, e, en_n);
            chk("rand_data", 64'(d), 64'(a * b));
            chk("rand_err", 64'(e), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
